// File: rtl/router_pkt_tx.sv
// Packet transmitter for the 1x3 router input: buffers a host payload, then sends header/payload/parity.
// Optional PARITY_INJ_EN adds inj_par_err, which flips bit 0 of the transmitted parity byte.
module router_pkt_tx #(
    parameter int GAP_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       start,
    input  logic [1:0] dest,
    input  logic [5:0] len,
    input  logic [7:0] pl_data,
    input  logic       pl_valid,
    output logic       pl_ready,
    input  logic       busy,
`ifdef PARITY_INJ_EN
    input  logic       inj_par_err,
`endif
    output logic       pkt_valid,
    output logic [7:0] data_out,
    output logic       tx_active,
    output logic       tx_done,
    output logic       err_cfg
);

    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE, LOAD, HEADER, PAYLOAD, PARITY, GAP
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    dest_q, dest_d;
    logic [5:0]    len_q, len_d;
    logic [5:0]    cnt_q, cnt_d;
    logic [5:0]    idx_q, idx_d;
    logic [7:0]    par_q, par_d;
    logic [GW-1:0] gap_q, gap_d;
    logic          err_q, err_d;
    logic          inj_q, inj_d;
    logic          buf_wr;
    logic [7:0]    pl_buf [64];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            dest_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            par_q   <= '0;
            gap_q   <= '0;
            err_q   <= 1'b0;
            inj_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dest_q  <= dest_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            par_q   <= par_d;
            gap_q   <= gap_d;
            err_q   <= err_d;
            inj_q   <= inj_d;
        end
    end

    // Payload storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (buf_wr) pl_buf[cnt_q] <= pl_data;
    end

    assign pl_ready = (state_q == LOAD) && (cnt_q < len_q);

    always_comb begin
        state_d = state_q;
        dest_d  = dest_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        par_d   = par_q;
        gap_d   = gap_q;
        inj_d   = inj_q;
        err_d   = 1'b0;
        buf_wr  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (dest != 2'd3 && len != 6'd0) begin
                        dest_d  = dest;
                        len_d   = len;
                        cnt_d   = '0;
                        par_d   = {len, dest};
`ifdef PARITY_INJ_EN
                        inj_d   = inj_par_err;
`else
                        inj_d   = 1'b0;
`endif
                        state_d = LOAD;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            LOAD: begin
                if (cnt_q == len_q) begin
                    state_d = HEADER;
                end else if (pl_valid) begin
                    buf_wr = 1'b1;
                    par_d  = par_q ^ pl_data;
                    cnt_d  = cnt_q + 6'd1;
                end
            end
            HEADER: begin
                if (!busy) begin
                    idx_d   = '0;
                    state_d = PAYLOAD;
                end
            end
            PAYLOAD: begin
                if (!busy) begin
                    idx_d = idx_q + 6'd1;
                    if (idx_q == len_q - 6'd1) state_d = PARITY;
                end
            end
            PARITY: begin
                if (!busy) begin
                    gap_d   = '0;
                    state_d = GAP;
                end
            end
            GAP: begin
                if (gap_q == GAP_LAST) state_d = IDLE;
                else gap_d = gap_q + GW'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs decode registered state only, so busy stalls simply hold them.
    always_comb begin
        data_out = 8'h00;
        case (state_q)
            HEADER:  data_out = {len_q, dest_q};
            PAYLOAD: data_out = pl_buf[idx_q];
            PARITY:  data_out = par_q ^ {7'b0, inj_q};
            default: data_out = 8'h00;
        endcase
    end

    assign pkt_valid = (state_q == HEADER) || (state_q == PAYLOAD);
    assign tx_active = (state_q != IDLE);
    assign tx_done   = (state_q == GAP) && (gap_q == '0);
    assign err_cfg   = err_q;

endmodule

// File: tb/tb_router_pkt_tx.sv
// Scoreboard bench for router_pkt_tx: expected frame bytes queued at start, checked by a monitor.
module tb_router_pkt_tx;

    logic       clk = 1'b0;
    logic       rstn;
    logic       start;
    logic [1:0] dest;
    logic [5:0] len;
    logic [7:0] pl_data;
    logic       pl_valid;
    logic       pl_ready;
    logic       busy;
    logic       inj;
    logic       pkt_valid;
    logic [7:0] data_out;
    logic       tx_active;
    logic       tx_done;
    logic       err_cfg;

    int tests = 0;
    int fails = 0;
    int done_cnt = 0;

    logic [8:0] exp_q[$];
    logic [7:0] pl_mem [64];

    always #5 clk = ~clk;

    router_pkt_tx #(.GAP_CYCLES(2)) dut (
        .clk(clk), .rstn(rstn), .start(start), .dest(dest), .len(len),
        .pl_data(pl_data), .pl_valid(pl_valid), .pl_ready(pl_ready), .busy(busy),
`ifdef PARITY_INJ_EN
        .inj_par_err(inj),
`endif
        .pkt_valid(pkt_valid), .data_out(data_out), .tx_active(tx_active),
        .tx_done(tx_done), .err_cfg(err_cfg)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: one check per consumed frame byte, plus a hold check after each busy cycle.
    logic       prev_pv = 1'b0;
    logic       par_phase = 1'b0;
    logic       hold_v = 1'b0;
    logic [8:0] hold_val;
    always begin
        @(negedge clk);
        #2;
        if (!rstn) begin
            prev_pv   = 1'b0;
            par_phase = 1'b0;
            hold_v    = 1'b0;
        end else begin
            logic active;
            if (hold_v) check("hold_under_busy", {23'b0, pkt_valid, data_out}, {23'b0, hold_val});
            hold_v = 1'b0;
            active = pkt_valid || prev_pv || par_phase;
            if (active) begin
                if (busy) begin
                    hold_v   = 1'b1;
                    hold_val = {pkt_valid, data_out};
                    if (!pkt_valid) par_phase = 1'b1;
                end else begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_byte", {23'b0, pkt_valid, data_out}, 32'hFFFF_FFFF);
                    end else begin
                        logic [8:0] e;
                        e = exp_q.pop_front();
                        check("frame_byte", {23'b0, pkt_valid, data_out}, {23'b0, e});
                        $display("[TB] byte pv=%0b data=%02h expected pv=%0b data=%02h",
                                 pkt_valid, data_out, e[8], e[7:0]);
                    end
                    if (!pkt_valid) par_phase = 1'b0;
                end
            end
            prev_pv = pkt_valid;
            if (tx_done) done_cnt++;
        end
    end

    task automatic start_pkt(input logic [1:0] d, input logic [5:0] l, input logic ij);
        logic [7:0] p;
        p = {l, d};
        exp_q.push_back({1'b1, l, d});
        for (int i = 0; i < int'(l); i++) begin
            exp_q.push_back({1'b1, pl_mem[i]});
            p = p ^ pl_mem[i];
        end
        exp_q.push_back({1'b0, p ^ {7'b0, ij}});
        @(negedge clk);
        start = 1'b1; dest = d; len = l; inj = ij;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic load_payload(input int l, input bit toggle);
        int i = 0;
        int cyc = 0;
        while (i < l && cyc < 600) begin
            @(negedge clk);
            pl_valid = !(toggle && cyc[0]);
            pl_data  = pl_mem[i];
            #1;
            check("no_pv_during_load", {31'b0, pkt_valid}, 32'd0);
            if (pl_valid && pl_ready) i++;
            cyc++;
        end
        check("load_complete", i, l);
        @(negedge clk);
        pl_valid = 1'b0;
    endtask

    task automatic drain_and_gap(input logic [7:0] stall_byte, input int stall_n);
        int sl = stall_n;
        int d0 = done_cnt;
        bit seen = 1'b0;
        for (int c = 0; c < 300 && !seen; c++) begin
            @(negedge clk);
            if (tx_done) begin
                seen = 1'b1;
                busy = 1'b0;
            end else if (pkt_valid && data_out == stall_byte && sl > 0) begin
                busy = 1'b1;
                sl--;
            end else begin
                busy = 1'b0;
            end
        end
        check("tx_done_seen", {31'b0, seen}, 32'd1);
        @(negedge clk); #1;
        check("gap2_active", {30'b0, tx_active, tx_done}, 32'd2);
        @(negedge clk); #1;
        check("idle_after_gap", {31'b0, tx_active}, 32'd0);
        #3;
        check("tx_done_once", done_cnt - d0, 1);
    endtask

    task automatic case1(input logic ij);
        pl_mem[0] = 8'h55;
        start_pkt(2'd1, 6'd1, ij);
        load_payload(1, 1'b0);
        drain_and_gap(8'h00, 0);
    endtask

    initial begin
        rstn = 1'b0; start = 1'b0; dest = '0; len = '0; pl_data = '0;
        pl_valid = 1'b0; busy = 1'b0; inj = 1'b0;
        #12;
        check("rst_outputs", {27'b0, pkt_valid, pl_ready, tx_active, tx_done, err_cfg}, 32'd0);
        check("rst_data_out", {24'b0, data_out}, 32'd0);
        @(negedge clk);
        rstn = 1'b1;

        // 1: single-byte packet
        case1(1'b0);

        // 2: busy for two cycles while 0x22 is driven
        pl_mem[0] = 8'h11; pl_mem[1] = 8'h22; pl_mem[2] = 8'h33;
        start_pkt(2'd2, 6'd3, 1'b0);
        load_payload(3, 1'b0);
        drain_and_gap(8'h22, 2);

        // 3: illegal configurations
        @(negedge clk);
        start = 1'b1; dest = 2'd3; len = 6'd5;
        @(negedge clk);
        start = 1'b0; #1;
        check("err_dest3", {28'b0, err_cfg, tx_active, pkt_valid, pl_ready}, 32'h8);
        @(negedge clk); #1;
        check("err_dest3_clear", {28'b0, err_cfg, tx_active, pkt_valid, pl_ready}, 32'h0);
        @(negedge clk);
        start = 1'b1; dest = 2'd0; len = 6'd0;
        @(negedge clk);
        start = 1'b0; #1;
        check("err_len0", {28'b0, err_cfg, tx_active, pkt_valid, pl_ready}, 32'h8);
        @(negedge clk); #1;
        check("err_len0_clear", {28'b0, err_cfg, tx_active, pkt_valid, pl_ready}, 32'h0);

        // 4: maximum length with a gappy host
        for (int i = 0; i < 63; i++) pl_mem[i] = 8'(i * 37 + 11);
        start_pkt(2'd0, 6'd63, 1'b0);
        load_payload(63, 1'b1);
        drain_and_gap(8'h00, 0);

        // 5: asynchronous reset on the third payload byte
        for (int i = 0; i < 5; i++) pl_mem[i] = 8'(8'hA1 + i);
        start_pkt(2'd2, 6'd5, 1'b0);
        load_payload(5, 1'b0);
        begin
            bit hit = 1'b0;
            for (int c = 0; c < 50 && !hit; c++) begin
                @(negedge clk);
                if (pkt_valid && data_out == 8'hA3) hit = 1'b1;
            end
            check("third_byte_seen", {31'b0, hit}, 32'd1);
        end
        #1 rstn = 1'b0;
        #1;
        check("async_rst", {22'b0, pkt_valid, tx_active, data_out}, 32'd0);
        exp_q.delete();
        @(negedge clk);
        rstn = 1'b1;
        case1(1'b0);

`ifdef PARITY_INJ_EN
        // 6: parity injection, then a clean packet
        case1(1'b1);
        case1(1'b0);
`endif

        repeat (3) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/router_pkt_tx.md
# router_pkt_tx

Packet transmitter for the 1x3 router's input port. Accepts a destination, a length and that many payload bytes from a host, buffers the whole payload, then drives the router's `pkt_valid`/`data_in` input as a contiguous header, payload and parity frame. Stalls on the router's `busy`. Sits upstream of the router top level, on the opposite end of the interface the router FSM receives on.

## Interface
- `GAP_CYCLES`, default 2: idle cycles inserted after each parity byte before a new `start` is accepted. Must be at least 1.
- `clk` in 1: single clock; all state changes on the rising edge.
- `rstn` in 1: asynchronous, active-low reset.
- `start` in 1: request a packet; sampled only in IDLE.
- `dest` in 2: destination FIFO 0..2, latched on `start`.
- `len` in 6: payload length 1..63, latched on `start`.
- `pl_data` in 8: payload byte from the host.
- `pl_valid` in 1: `pl_data` is valid.
- `pl_ready` out 1: block will store `pl_data` this cycle.
- `busy` in 1: router busy; the driven byte is not consumed this cycle.
- `pkt_valid` out 1: high during header and payload bytes.
- `data_out` out 8: byte to the router's data input.
- `tx_active` out 1: state is not IDLE.
- `tx_done` out 1: one-cycle pulse on the first GAP cycle.
- `err_cfg` out 1: one-cycle pulse when `start` carries an illegal `dest`/`len`.

## Operation
- States: IDLE, LOAD, HEADER, PAYLOAD, PARITY, GAP.
- **IDLE**
  - If `start` and `dest` != 3 and `len` != 0: latch `dest` and `len`, set `cnt` = 0, seed `par` = {len, dest}, go to LOAD.
  - If `start` with `dest` == 3 or `len` == 0: pulse `err_cfg` for 1 cycle and stay in IDLE.
- **LOAD**
  - `pl_ready` = 1 while `cnt` < `len`.
  - Each `pl_valid` && `pl_ready` writes `buf[cnt]` = `pl_data`, then `par` ^= `pl_data` and `cnt`++.
  - When `cnt` reaches `len`, go to HEADER on the next edge. `pl_valid` gaps only delay this.
- **HEADER**
  - `pkt_valid` = 1, `data_out` = {len[5:0], dest[1:0]}.
  - On an edge with `busy` = 0: `idx` = 0, go to PAYLOAD.
- **PAYLOAD**
  - `pkt_valid` = 1, `data_out` = `buf[idx]`.
  - On an edge with `busy` = 0: `idx`++. After byte `len`-1 is consumed, go to PARITY.
- **PARITY**
  - `pkt_valid` = 0, `data_out` = `par`.
  - On an edge with `busy` = 0, go to GAP.
- **GAP**
  - `pkt_valid` = 0, `data_out` = 0.
  - Lasts `GAP_CYCLES` cycles, then IDLE. `tx_done` is high on the first GAP cycle only.
- Buffer: 64x8 register array. Contents are not reset.
- Parity is the 8-bit XOR of the header byte and all payload bytes.
- `start` is ignored outside IDLE. `pl_ready` = 0 outside LOAD.
- While `busy` = 1, `data_out` and `pkt_valid` hold their values.

## Timing
- Reset values, applied immediately on `rstn` = 0 (asynchronous):
  - state IDLE.
  - `pkt_valid`, `pl_ready`, `tx_active`, `tx_done`, `err_cfg` = 0.
  - `data_out` = 0x00.
  - `cnt`, `idx`, `par` = 0.
- Reset mid-packet aborts the frame (`pkt_valid` drops asynchronously). The next `start` after reset is handled normally.
- `start` to the first LOAD cycle: 1 clock.
- Last payload byte stored to HEADER: 1 clock.
- Frame length with no stalls: `len` + 2 cycles (header + payload + parity). Each `busy` cycle adds 1.
- All outputs are registered, or decoded from the registered state only. There is no combinational path from `busy` or `pl_valid` to any output except `pl_ready`, which depends only on state and `cnt`.
- `pkt_valid` stays high from header through the last payload byte, with no gaps. The frame ends when `pkt_valid` falls with the parity byte on `data_out`.

## Configuration
- `PARITY_INJ_EN` defined:
  - Adds input `inj_par_err` (1 bit), latched on an accepted `start`.
  - When the latched value is 1, the transmitted parity byte is `par` ^ 8'h01.
- `PARITY_INJ_EN` undefined: the port is absent and parity is always correct.

## Test plan
1. `dest`=1, `len`=1, payload 0x55, `busy`=0 -> `data_out` 0x05 (`pkt_valid`=1), then 0x55 (`pkt_valid`=1), then 0x50 (`pkt_valid`=0); `tx_done` pulses once; IDLE after 2 GAP cycles.
2. `dest`=2, `len`=3, payload 0x11/0x22/0x33, `busy`=1 for 2 cycles while 0x22 is driven -> 0x0E, 0x11, 0x22 held 3 cycles, 0x33, parity 0x0E; `pkt_valid` never drops before parity.
3. `start` with `dest`=3, then `start` with `dest`=0/`len`=0 -> `err_cfg` pulses once each; `tx_active`, `pkt_valid`, `pl_ready` stay 0.
4. `dest`=0, `len`=63, `pl_valid` toggled every other cycle -> no `pkt_valid` until 63 bytes are stored; header 0xFC; 63 payload bytes in order; parity equals the XOR of 0xFC and the payload.
5. `rstn` low while the third payload byte of a `len`=5 packet is driven -> `pkt_valid`/`data_out`/`tx_active` = 0 immediately; a following `dest`=1/`len`=1/0x55 packet gives case 1 output exactly.
6. With `PARITY_INJ_EN`, case 1 with `inj_par_err`=1 -> parity byte 0x51; the next packet with `inj_par_err`=0 -> 0x50.
